// File: rtl/bids22_round_sequencer_pkg.sv
// bids22defs: shared types for the bids22 core and its host-side round sequencer.
//   opcode_t    - core control-port opcodes
//   err_t       - core error codes reported on core_err
//   seq_state_t - round sequencer FSM states
//   seq_cmd_t   - one queued host command (opcode + operand)
package bids22defs;

  typedef enum logic [2:0] {
    NO_OP         = 3'd0,
    LOCK          = 3'd1,
    UNLOCK        = 3'd2,
    LOADX         = 3'd3,
    LOADY         = 3'd4,
    LOADMASK      = 3'd5,
    SETBIDCHARGE  = 3'd6,
    SETXBIDCHARGE = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    NOERROR          = 3'd0,
    BADKEY           = 3'd1,
    ALREADY_LOCKED   = 3'd2,
    ALREADY_UNLOCKED = 3'd3,
    LOCKED           = 3'd4,
    INVALID_OP       = 3'd5
  } err_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam int unsigned SEQ_DATAWIDTH = 32;

  typedef struct packed {
    opcode_t                  op;
    logic [SEQ_DATAWIDTH-1:0] data;
  } seq_cmd_t;

endpackage

// File: rtl/bids22_cmd_fifo.sv
// bids22_cmd_fifo: synchronous command FIFO with occupancy count.
//   clk, rst_n     - clock, asynchronous active-low reset (empties the queue)
//   push_i/push_data_i - write request and entry; ignored when full
//   pop_i          - read request; ignored when empty
//   head_o         - oldest entry (valid while !empty_o)
//   count_o, full_o, empty_o - occupancy status (registered)
module bids22_cmd_fifo
  import bids22defs::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         cmd_t = seq_cmd_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  cmd_t                     push_data_i,
  input  logic                     pop_i,
  output cmd_t                     head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_en, pop_en;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // A push into a full queue is refused even when a pop frees a slot this cycle.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (push_en && !pop_en)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!push_en && pop_en) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_en) wr_q <= wr_q + AW'(1);
      if (pop_en)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/bids22_round_sequencer.sv
// bids22_round_sequencer: host-side controller for the bids22 auction core.
//   Host side : host_valid/host_ready/host_op/host_data push configuration
//               commands; round_req/round_len request a timed bidding round;
//               busy reports activity.
//   Core side : C_op/C_data issue one queued command per cycle (registered),
//               C_start is held for the programmed round length; core_ready,
//               core_err, core_roundOver, core_maxBid come back from the core.
//   Results   : result_valid pulses with result_maxbid at the end of a round;
//               cfg_err holds the first core error seen on an issued op;
//               seq_err flags roundOver timeouts and misplaced round requests.
module bids22_round_sequencer
  import bids22defs::*;
#(
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned FIFODEPTH   = 4,
  parameter int unsigned LENWIDTH    = 16,
  parameter int unsigned OVERTIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  opcode_t              host_op,
  input  logic [DATAWIDTH-1:0] host_data,
  input  logic                 round_req,
  input  logic [LENWIDTH-1:0]  round_len,
  output logic                 busy,
  output opcode_t              C_op,
  output logic [DATAWIDTH-1:0] C_data,
  output logic                 C_start,
  input  logic                 core_ready,
  input  err_t                 core_err,
  input  logic                 core_roundOver,
  input  logic [DATAWIDTH-1:0] core_maxBid,
  output logic                 result_valid,
  output logic [DATAWIDTH-1:0] result_maxbid,
  output err_t                 cfg_err,
  output logic                 seq_err
);

  localparam int unsigned TW = $clog2(OVERTIMEOUT + 1);

  typedef struct packed {
    opcode_t              op;
    logic [DATAWIDTH-1:0] data;
  } host_cmd_t;

  host_cmd_t                  push_cmd, head_cmd;
  logic [$clog2(FIFODEPTH):0] q_count;
  logic                       q_full, q_empty, pop_req, pop_acc, push_acc;

  seq_state_t           state_q, state_d;
  logic                 pend_q, pend_d;
  logic [LENWIDTH-1:0]  plen_q, plen_d;
  logic [LENWIDTH-1:0]  rcnt_q, rcnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  opcode_t              cop_q, cop_d;
  logic [DATAWIDTH-1:0] cdata_q, cdata_d;
  logic [DATAWIDTH-1:0] res_q, res_d;
  err_t                 cfg_q, cfg_d;
  logic                 seq_q, seq_d;

  assign push_cmd = '{op: host_op, data: host_data};
  assign push_acc = host_valid && !q_full;
  assign pop_req  = core_ready && ((state_q == IDLE) || (state_q == ISSUE));
  assign pop_acc  = pop_req && !q_empty;

  bids22_cmd_fifo #(
    .DEPTH (FIFODEPTH),
    .cmd_t (host_cmd_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (host_valid),
    .push_data_i (push_cmd),
    .pop_i       (pop_req),
    .head_o      (head_cmd),
    .count_o     (q_count),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    plen_d  = plen_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    res_d   = res_q;
    cfg_d   = cfg_q;
    seq_d   = seq_q;
    cop_d   = NO_OP;
    cdata_d = '0;

    if (pop_acc) begin
      cop_d   = head_cmd.op;
      cdata_d = head_cmd.data;
    end

    unique case (state_q)
      IDLE: begin
        if (!q_empty) begin
          state_d = ISSUE;
        end else if (pend_q) begin
          state_d = START;
          pend_d  = 1'b0;
          rcnt_d  = (plen_q == '0) ? LENWIDTH'(1) : plen_q;
        end
      end
      ISSUE: begin
        if (q_empty) state_d = IDLE;
      end
      START: begin
        if (rcnt_q <= LENWIDTH'(1)) begin
          state_d = WAIT;
          tcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q - LENWIDTH'(1);
        end
      end
      WAIT: begin
        // The maxBid seen in the final WAIT cycle is the last capture.
        if (core_roundOver) begin
          state_d = DONE;
          res_d   = core_maxBid;
        end else if (tcnt_q >= TW'(OVERTIMEOUT - 1)) begin
          state_d = DONE;
          res_d   = core_maxBid;
          seq_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Applied after the state decode so a request in the same cycle as the
    // IDLE->START hand-off queues the next round.
    if (round_req) begin
      if (state_q == IDLE) begin
        pend_d = 1'b1;
        plen_d = round_len;
      end else begin
        seq_d = 1'b1;
      end
    end

    // A host NO_OP push clears the error and takes priority over a new latch.
    if (push_acc && (host_op == NO_OP)) begin
      cfg_d = NOERROR;
    end else if ((cop_q != NO_OP) && (cfg_q == NOERROR) && (core_err != NOERROR)) begin
      cfg_d = core_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      plen_q  <= '0;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      cop_q   <= NO_OP;
      cdata_q <= '0;
      res_q   <= '0;
      cfg_q   <= NOERROR;
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      plen_q  <= plen_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      cop_q   <= cop_d;
      cdata_q <= cdata_d;
      res_q   <= res_d;
      cfg_q   <= cfg_d;
      seq_q   <= seq_d;
    end
  end

  // Decoded straight from the state register so an async reset drops C_start at once.
  assign C_start       = (state_q == START);
  assign result_valid  = (state_q == DONE);
  assign busy          = (state_q != IDLE) || (q_count != '0);
  assign host_ready    = !q_full;
  assign C_op          = cop_q;
  assign C_data        = cdata_q;
  assign result_maxbid = res_q;
  assign cfg_err       = cfg_q;
  assign seq_err       = seq_q;

endmodule

// File: tb/tb_bids22_round_sequencer.sv
// Testbench for bids22_round_sequencer: directed scenarios followed by random
// traffic, every output compared each cycle against a behavioural model.
module tb_bids22_round_sequencer;
  import bids22defs::*;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int TO = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  opcode_t       host_op = NO_OP;
  logic [DW-1:0] host_data = '0;
  logic          round_req = 1'b0;
  logic [LW-1:0] round_len = '0;
  logic          busy;
  opcode_t       C_op;
  logic [DW-1:0] C_data;
  logic          C_start;
  logic          core_ready = 1'b1;
  err_t          core_err = NOERROR;
  logic          core_roundOver = 1'b0;
  logic [DW-1:0] core_maxBid = '0;
  logic          result_valid;
  logic [DW-1:0] result_maxbid;
  err_t          cfg_err;
  logic          seq_err;

  always #5 clk = ~clk;

  bids22_round_sequencer #(
    .DATAWIDTH   (DW),
    .FIFODEPTH   (DEPTH),
    .LENWIDTH    (LW),
    .OVERTIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_op        (host_op),
    .host_data      (host_data),
    .round_req      (round_req),
    .round_len      (round_len),
    .busy           (busy),
    .C_op           (C_op),
    .C_data         (C_data),
    .C_start        (C_start),
    .core_ready     (core_ready),
    .core_err       (core_err),
    .core_roundOver (core_roundOver),
    .core_maxBid    (core_maxBid),
    .result_valid   (result_valid),
    .result_maxbid  (result_maxbid),
    .cfg_err        (cfg_err),
    .seq_err        (seq_err)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    opcode_t       op;
    logic [DW-1:0] data;
  } cmd_s;

  cmd_s          mq[$];        // commands waiting to be issued
  opcode_t       m_cop;        // op presented to the core this cycle
  logic [DW-1:0] m_cdata;
  bit            m_pend;       // round requested, waiting for queue to drain
  int            m_plen;
  int            m_start_left; // C_start cycles still to run
  bit            m_waiting;    // round closed, waiting on roundOver
  int            m_waited;     // cycles spent waiting so far
  bit            m_done;       // result pulse this cycle
  bit            m_drain;      // draining the queue (not accepting rounds)
  logic [DW-1:0] m_res;
  err_t          m_cfg;
  bit            m_seq;
  int            cstart_cnt = 0;
  int            ops_seen = 0;

  function automatic void model_reset();
    mq.delete();
    m_cop = NO_OP; m_cdata = '0; m_pend = 0; m_plen = 0;
    m_start_left = 0; m_waiting = 0; m_waited = 0; m_done = 0; m_drain = 0;
    m_res = '0; m_cfg = NOERROR; m_seq = 0;
  endfunction

  function automatic void model_step();
    int      qsz = mq.size();
    bit      in_round = (m_start_left > 0) || m_waiting || m_done;
    bit      accepting_round = !in_round && !m_drain;
    bit      pop = core_ready && (qsz > 0) && !in_round;
    bit      push = host_valid && (qsz < DEPTH);
    opcode_t n_cop = NO_OP;
    logic [DW-1:0] n_cdata = '0;
    if (pop) begin
      n_cop = mq[0].op;
      n_cdata = mq[0].data;
    end
    if (push && host_op == NO_OP) m_cfg = NOERROR;
    else if (m_cop != NO_OP && m_cfg == NOERROR && core_err != NOERROR) m_cfg = core_err;

    if (m_done) begin
      m_done = 0;
    end else if (m_waiting) begin
      if (core_roundOver) begin
        m_waiting = 0; m_done = 1; m_res = core_maxBid;
      end else if (m_waited + 1 >= TO) begin
        m_waiting = 0; m_done = 1; m_res = core_maxBid; m_seq = 1;
      end else begin
        m_waited++;
      end
    end else if (m_start_left > 0) begin
      m_start_left--;
      if (m_start_left == 0) begin
        m_waiting = 1; m_waited = 0;
      end
    end else if (m_drain) begin
      if (qsz == 0) m_drain = 0;
    end else begin
      if (qsz > 0) m_drain = 1;
      else if (m_pend) begin
        m_start_left = (m_plen == 0) ? 1 : m_plen;
        m_pend = 0;
      end
    end

    if (round_req) begin
      if (accepting_round) begin
        m_pend = 1; m_plen = int'(round_len);
      end else begin
        m_seq = 1;
      end
    end

    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{host_op, host_data});
    m_cop = n_cop;
    m_cdata = n_cdata;
  endfunction

  task automatic compare_all();
    bit m_busy = (mq.size() > 0) || m_drain || (m_start_left > 0) || m_waiting || m_done;
    check_eq("host_ready", 64'(host_ready), 64'(mq.size() < DEPTH));
    check_eq("busy", 64'(busy), 64'(m_busy));
    check_eq("C_op", 64'(C_op), 64'(m_cop));
    check_eq("C_data", 64'(C_data), 64'(m_cdata));
    check_eq("C_start", 64'(C_start), 64'(m_start_left > 0));
    check_eq("result_valid", 64'(result_valid), 64'(m_done));
    check_eq("result_maxbid", 64'(result_maxbid), 64'(m_res));
    check_eq("cfg_err", 64'(cfg_err), 64'(m_cfg));
    check_eq("seq_err", 64'(seq_err), 64'(m_seq));
  endtask

  always @(negedge clk) begin
    if (!reset_n) model_reset();
    compare_all();
    if (C_start) cstart_cnt++;
    if (C_op != NO_OP) ops_seen++;
    if (reset_n) model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    round_req = 1'b0;
    core_roundOver = 1'b0;
  endtask

  task automatic push(input opcode_t op, input logic [DW-1:0] data);
    host_valid = 1'b1;
    host_op = op;
    host_data = data;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin ok = 1; break; end
      tick();
    end
    check_eq(tag, 64'(ok), 64'(1));
  endtask

  task automatic wait_cstart(input bit level, input string tag);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (C_start == level) begin ok = 1; break; end
      tick();
    end
    check_eq(tag, 64'(ok), 64'(1));
  endtask

  initial begin
    bit seen;
    int n;
    logic [2:0] rnd3;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_host_ready", 64'(host_ready), 64'(1));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_C_op", 64'(C_op), 64'(NO_OP));
    check_eq("rst_C_start", 64'(C_start), 64'(0));
    reset_n = 1'b1;
    tick();

    // 1: three ops issued back-to-back
    core_ready = 1'b1;
    ops_seen = 0;
    push(LOADX, 32'd5);
    push(SETBIDCHARGE, 32'd1);
    push(LOCK, 32'hAB);
    wait_idle("t1_idle");
    check_eq("t1_ops", 64'(ops_seen), 64'(3));

    // 2: queue full with core stalled
    core_ready = 1'b0;
    ops_seen = 0;
    for (int i = 0; i < 5; i++) begin
      rnd3 = 3'($urandom_range(1, 7));
      push(opcode_t'(rnd3), $urandom);
    end
    check_eq("t2_full", 64'(host_ready), 64'(0));
    check_eq("t2_stalled", 64'(ops_seen), 64'(0));
    core_ready = 1'b1;
    wait_idle("t2_idle");
    check_eq("t2_ops", 64'(ops_seen), 64'(4));

    // 3: round of length 3, roundOver two cycles into the wait
    cstart_cnt = 0;
    round_req = 1'b1; round_len = 16'd3;
    tick();
    wait_cstart(1'b1, "t3_start_seen");
    wait_cstart(1'b0, "t3_start_end");
    core_maxBid = $urandom;
    tick();
    core_roundOver = 1'b1; core_maxBid = 32'd7;
    tick();
    core_maxBid = $urandom;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (result_valid) begin seen = 1; break; end
      tick();
    end
    check_eq("t3_result_seen", 64'(seen), 64'(1));
    check_eq("t3_maxbid", 64'(result_maxbid), 64'(7));
    check_eq("t3_cstart_cycles", 64'(cstart_cnt), 64'(3));
    check_eq("t3_seq_err", 64'(seq_err), 64'(0));
    tick();

    // 4: zero length round, no roundOver -> timeout
    cstart_cnt = 0;
    round_req = 1'b1; round_len = 16'd0;
    tick();
    wait_cstart(1'b1, "t4_start_seen");
    wait_cstart(1'b0, "t4_start_end");
    seen = 0; n = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) begin seen = 1; break; end
      tick();
      n++;
    end
    check_eq("t4_result_seen", 64'(seen), 64'(1));
    check_eq("t4_wait_cycles", 64'(n), 64'(TO));
    check_eq("t4_seq_err", 64'(seq_err), 64'(1));
    check_eq("t4_cstart_cycles", 64'(cstart_cnt), 64'(1));
    tick();

    // 5: cfg_err latch, stickiness and clear
    core_err = BADKEY;
    push(UNLOCK, 32'd0);
    repeat (3) tick();
    check_eq("t5_latched", 64'(cfg_err), 64'(BADKEY));
    core_err = LOCKED;
    push(LOCK, 32'd1);
    repeat (3) tick();
    check_eq("t5_sticky", 64'(cfg_err), 64'(BADKEY));
    core_err = NOERROR;
    push(NO_OP, 32'd0);
    tick();
    check_eq("t5_cleared", 64'(cfg_err), 64'(NOERROR));
    wait_idle("t5_idle");

    // 6: asynchronous reset during START
    round_req = 1'b1; round_len = 16'd10;
    tick();
    wait_cstart(1'b1, "t6_start_seen");
    push(LOADX, 32'd1);
    push(LOADY, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_C_start", 64'(C_start), 64'(0));
    check_eq("t6_busy", 64'(busy), 64'(0));
    check_eq("t6_host_ready", 64'(host_ready), 64'(1));
    check_eq("t6_seq_err", 64'(seq_err), 64'(0));
    check_eq("t6_C_op", 64'(C_op), 64'(NO_OP));
    check_eq("t6_result_maxbid", 64'(result_maxbid), 64'(0));
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // 7: random traffic
    for (int i = 0; i < 800; i++) begin
      host_valid = ($urandom_range(0, 2) == 0);
      rnd3 = 3'($urandom_range(0, 7));
      host_op = opcode_t'(rnd3);
      host_data = $urandom;
      core_ready = ($urandom_range(0, 3) != 0);
      rnd3 = 3'($urandom_range(1, 5));
      core_err = ($urandom_range(0, 5) == 0) ? err_t'(rnd3) : NOERROR;
      round_req = ($urandom_range(0, 19) == 0);
      round_len = 16'($urandom_range(0, 5));
      core_roundOver = ($urandom_range(0, 7) == 0);
      core_maxBid = $urandom;
      @(posedge clk);
      #1;
    end
    host_valid = 1'b0; round_req = 1'b0; core_roundOver = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
